// File: rtl/spi_slave_param_pkg.sv
// Shared definitions for the parametrised SPI slave:
// mode encodings, FSM state type and counter width helper.
package spi_slave_param_pkg;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  function automatic int cnt_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// Client-side receive/transmit handshake bundle
// between the SPI slave and its register/FIFO user.
interface spi_slave_param_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_overrun;
  logic              rx_hold;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic              frame_active;

  modport master (
    input  rx_data, rx_valid, rx_overrun,
    input  tx_ready, tx_underrun, frame_active,
    output rx_hold, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_overrun,
    output tx_ready, tx_underrun, frame_active,
    input  rx_hold, tx_data, tx_valid
  );
endinterface

// File: rtl/spi_slave_param_sync_edge.sv
// N-stage synchroniser with registered-level
// rise/fall strobes for an asynchronous input.
module spi_slave_param_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: any CPOL/CPHA, bit order,
// word width, back-to-back words, tx handshake.
module spi_slave_param
  import spi_slave_param_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter bit              CPOL        = 1'b0,
  parameter bit              CPHA        = 1'b0,
  parameter bit              MSB_FIRST   = 1'b1,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE   = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  input  logic ssel,
  output logic miso,
  spi_slave_param_if.slave bus
);
  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_ssel_q, w_ssel_rise, w_ssel_fall;
  logic w_mosi, w_lead, w_trail;
  logic w_sample, w_shift, w_load_bit, w_shl_bit;
  logic [DATA_W-1:0] w_rx_next, w_load_word, w_tx_shl;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rx_sr, r_tx_sr, r_rx_data;
  logic r_load_pend, r_miso;
  logic r_rx_valid, r_rx_overrun;
  logic r_tx_ready, r_tx_underrun;

  spi_slave_param_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(CPOL)
  ) u_sck (
    .clk   (clk),
    .rst   (rst),
    .i_d   (sck),
    .o_q   (w_sck_q),
    .o_rise(w_sck_rise),
    .o_fall(w_sck_fall)
  );

  spi_slave_param_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_ssel (
    .clk   (clk),
    .rst   (rst),
    .i_d   (ssel),
    .o_q   (w_ssel_q),
    .o_rise(w_ssel_rise),
    .o_fall(w_ssel_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_sync <= '0;
    else r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign w_lead   = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail  = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_shift  = CPHA ? w_lead : w_trail;

  assign w_rx_next = MSB_FIRST ?
    {r_rx_sr[DATA_W-2:0], w_mosi} :
    {w_mosi, r_rx_sr[DATA_W-1:1]};
  assign w_tx_shl = MSB_FIRST ?
    {r_tx_sr[DATA_W-2:0], 1'b0} :
    {1'b0, r_tx_sr[DATA_W-1:1]};
  assign w_load_word = bus.tx_valid ? bus.tx_data : TX_IDLE;
  assign w_load_bit  = MSB_FIRST ?
    w_load_word[DATA_W-1] : w_load_word[0];
  assign w_shl_bit   = MSB_FIRST ?
    w_tx_shl[DATA_W-1] : w_tx_shl[0];

  // ssel edges stand in for its level: IDLE is left
  // only on a fall, ACTIVE only ever ends on a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_rx_sr       <= '0;
      r_tx_sr       <= '0;
      r_rx_data     <= '0;
      r_load_pend   <= 1'b0;
      r_miso        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          r_cnt  <= '0;
          if (w_ssel_fall) begin
            r_state     <= ST_ACTIVE;
            r_load_pend <= CPHA;
            if (!CPHA) begin
              r_tx_sr       <= w_load_word;
              r_miso        <= w_load_bit;
              r_tx_ready    <= bus.tx_valid;
              r_tx_underrun <= ~bus.tx_valid;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_ssel_rise) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_miso      <= 1'b0;
            r_load_pend <= 1'b0;
          end else begin
            if (w_shift) begin
              if (r_load_pend) begin
                r_load_pend   <= 1'b0;
                r_tx_sr       <= w_load_word;
                r_miso        <= w_load_bit;
                r_tx_ready    <= bus.tx_valid;
                r_tx_underrun <= ~bus.tx_valid;
              end else begin
                r_tx_sr <= w_tx_shl;
                r_miso  <= w_shl_bit;
              end
            end
            if (w_sample) begin
              r_rx_sr <= w_rx_next;
              if (r_cnt == LAST) begin
                r_cnt        <= '0;
                r_rx_data    <= w_rx_next;
                r_rx_valid   <= 1'b1;
                r_rx_overrun <= bus.rx_hold;
                r_load_pend  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso             = r_miso;
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_overrun   = r_rx_overrun;
  assign bus.tx_ready     = r_tx_ready;
  assign bus.tx_underrun  = r_tx_underrun;
  assign bus.frame_active = ~w_ssel_q;
endmodule
